mux_arb_way: RTL and testbench
==============================

# mux_arb_way

Parametrised registered N-way multiplexer with per-channel valid/ready handshake and selectable fixed-priority or round-robin arbitration. Generalises the combinational 8-way 16-bit mux to WAYS channels of WIDTH bits and adds a one-deep output register, so several producers (memory-mapped peripherals, screen/keyboard ports, DMA sources) can share one downstream bus without external select logic. It sits between producer blocks and a single consumer, such as the CPU data-in path or a bus bridge.

## Interface
- WIDTH, 16, data bits per channel (≥1)
- WAYS, 8, number of input channels (2..16)
- MODE, 1, arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin
- SEL_W, derived = clog2(WAYS), width of channel index; not overridable
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  WAYS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  WAYS  channel i presents a word
- in_ready  out  WAYS  channel i word accepted this cycle when in_valid[i] & in_ready[i]
- out_data  out  WIDTH  registered selected word
- out_sel  out  SEL_W  index of channel that produced out_data
- out_valid  out  1  out_data/out_sel hold a word
- out_ready  in  1  consumer accepts when out_valid & out_ready

## Operation
- load = ~out_valid | out_ready; the output register can accept a word this cycle.
- The arbiter produces a one-hot grant among asserted in_valid bits. in_ready[i] = grant[i] & load. At most one in_ready bit is high per cycle. in_ready is all-zero when no in_valid is set.
- MODE 0: grant goes to the lowest-index valid channel.
- MODE 1: the search starts at (last + 1) mod WAYS and wraps. `last` updates to the granted index only on an accepted transfer. A stalled grant does not advance `last`.
- On an accepted transfer: out_data ← in_data of the granted channel, out_sel ← its index, out_valid ← 1.
- If out_ready & out_valid and no input transfers: out_valid ← 0. out_data and out_sel hold their last values.
- Simultaneous drain and load: the new word replaces the old with no bubble, so throughput is 1 word/cycle.
- Producer rules: in_valid must not depend on in_ready. Once asserted, valid and data hold until accepted. The consumer may toggle out_ready freely.
- out_valid never depends combinationally on out_ready.

## Timing
- Reset (synchronous, takes priority over everything) sets out_valid=0, out_data=0, out_sel=0, last=WAYS-1. After reset, the first round-robin grant is channel 0.
- Reset asserted mid-transfer discards the held word. in_ready is forced to 0 during the reset cycle.
- Latency from input acceptance to out_valid is 1 cycle.
- Combinational paths: in_valid → in_ready and out_ready → in_ready. No input-to-out_data combinational path.
- Backpressure: while out_valid=1 and out_ready=0, all in_ready=0 and the output register is stable.
- Round-robin fairness: with all WAYS channels continuously valid and out_ready=1, each channel is served exactly once per WAYS consecutive cycles.

## Structure
- Shared package mux_pkg holds:
  - the MODE constants ARB_FIXED=0 and ARB_RR=1;
  - the clog2 constant function used to derive SEL_W.
- One sub-module, rr_arbiter, is parametrised by WAYS and MODE. It takes req[WAYS], advance and clk/reset, and outputs grant[WAYS] and grant_idx[SEL_W]. It owns the `last` pointer.
- The top level holds the output register, the load logic and the data select (an AND-OR over the one-hot grant).

## Test plan
- **Reset values:** assert reset 2 cycles with all inputs valid → out_valid=0, out_data=0, out_sel=0, in_ready=0. The first cycle after release grants channel 0.
- **Round-robin rotation:** WAYS=8, MODE=1, all valid, channel i data=16'h1000+i, out_ready=1 → out_sel sequence 0,1,…,7,0 on consecutive cycles; out_data matches each index.
- **Wrap and skip:** MODE=1, only channels 2 and 6 valid → out_sel alternates 2,6,2,6; no cycles are granted to idle channels.
- **Fixed priority:** MODE=0, channels 1 and 5 valid continuously → out_sel=1 every cycle. After channel 1 drops, out_sel=5.
- **Backpressure:** out_ready=0 for 4 cycles with channel 3 valid (data 16'hBEEF) → out_data=16'hBEEF and out_valid=1 are held, and in_ready=0 for the whole stall. The first out_ready=1 cycle accepts the next word with no bubble.
- **Parametric build:** WIDTH=8, WAYS=3 → SEL_W=2; the rotation 0,1,2,0 wraps correctly and never emits index 3.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared constants and helpers for the mux_arb_way block.
//            ARB_FIXED / ARB_RR select the arbitration policy; clog2 derives
//            the channel-index width from the number of ways.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2, usable in constant expressions (parameter derivation).
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arb_way_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_way_if
// Purpose  : Bundles the producer-side channels and consumer-side output of
//            mux_arb_way.
//   in_data   [WAYS*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   in_valid  [WAYS]       channel i presents a word
//   in_ready  [WAYS]       channel i word accepted this cycle
//   out_data  [WIDTH]      registered selected word
//   out_sel   [SEL_W]      index of channel that produced out_data
//   out_valid              out_data/out_sel hold a word
//   out_ready              consumer accepts the held word
// Modports : slave  - the mux itself
//            master - the surrounding producers/consumer
// Revision : 1.0 - initial release
// ============================================================================
interface mux_arb_way_if #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8
);
    import mux_pkg::*;

    localparam int SEL_W = clog2(WAYS);

    logic [WAYS*WIDTH-1:0] in_data;
    logic [WAYS-1:0]       in_valid;
    logic [WAYS-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );

endinterface
`default_nettype wire

// File: rtl/mux_arb_way_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : One-hot arbiter over WAYS requesters. MODE ARB_FIXED grants the
//            lowest requesting index; MODE ARB_RR searches from the channel
//            after the last served one and wraps.
//   clk, reset          clock, synchronous active-high reset
//   req       [WAYS]    request vector
//   advance             a grant was accepted this cycle; record it as `last`
//   grant     [WAYS]    one-hot grant (all zero when no request)
//   grant_idx [SEL_W]   binary index of the granted channel
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int WAYS  = 8,
    parameter  int MODE  = ARB_RR,
    localparam int SEL_W = clog2(WAYS)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WAYS-1:0]  req,
    input  wire logic             advance,
    output logic      [WAYS-1:0]  grant,
    output logic      [SEL_W-1:0] grant_idx
);

    // Index of the most recently served channel. Reset to WAYS-1 so the
    // first round-robin search begins at channel 0.
    logic [SEL_W-1:0] r_last;

    int               w_start;
    int               w_cand;
    logic             w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        w_start   = 0;

        if (MODE == ARB_RR) begin
            w_start = (int'(r_last) == WAYS - 1) ? 0 : int'(r_last) + 1;
        end

        // Walk all channels once starting at w_start; first requester wins.
        for (int k = 0; k < WAYS; k++) begin
            w_cand = w_start + k;
            if (w_cand >= WAYS) begin
                w_cand = w_cand - WAYS;
            end
            if (!w_found && req[SEL_W'(w_cand)]) begin
                grant[SEL_W'(w_cand)] = 1'b1;
                grant_idx             = SEL_W'(w_cand);
                w_found               = 1'b1;
            end
        end
    end

    // A stalled grant leaves the pointer alone so the same channel keeps
    // priority until it is actually served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= SEL_W'(WAYS - 1);
        end else if (advance) begin
            r_last <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_arb_way.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_way
// Purpose  : Registered WAYS-to-1 multiplexer with per-channel valid/ready
//            handshake and fixed-priority or round-robin arbitration.
//            A one-deep output register supports 1 word/cycle throughput.
//   clk       clock, all state updates on rising edge
//   reset     synchronous active-high reset, highest priority
//   bus       mux_arb_way_if.slave (channels in, selected word out)
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_way
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int WAYS  = 8,
    parameter  int MODE  = ARB_RR,
    localparam int SEL_W = clog2(WAYS)
) (
    input wire logic      clk,
    input wire logic      reset,
    mux_arb_way_if.slave  bus
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    logic             w_load;
    logic             w_accept;
    logic [WAYS-1:0]  w_grant;
    logic [WAYS-1:0]  w_in_ready;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_masked [WAYS];
    logic [WIDTH-1:0] w_sel_data;

    // Output register is free, or is being drained this very cycle.
    assign w_load     = ~r_out_valid | bus.out_ready;
    assign w_in_ready = reset ? '0 : (w_grant & {WAYS{w_load}});
    assign w_accept   = |w_in_ready;

    rr_arbiter #(
        .WAYS (WAYS),
        .MODE (MODE)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.in_valid),
        .advance   (w_accept),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // AND-OR select: grant is one-hot, so OR-ing masked channels yields the
    // granted word without a wide binary-indexed mux.
    generate
        for (genvar i = 0; i < WAYS; i++) begin : g_sel
            assign w_masked[i] = bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}};
        end
    endgenerate

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_sel_data = w_sel_data | w_masked[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant_idx;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            // Drained with nothing new: data/sel keep their last values.
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_way.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_way
// Purpose  : Self-checking bench for mux_arb_way. Three builds run in lock
//            step (16x8 round-robin, 16x8 fixed priority, 8x3 round-robin)
//            against a channel-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_way;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_arb_way_if #(.WIDTH(16), .WAYS(8)) if_rr ();
    mux_arb_way_if #(.WIDTH(16), .WAYS(8)) if_fx ();
    mux_arb_way_if #(.WIDTH(8),  .WAYS(3)) if_sm ();

    mux_arb_way #(.WIDTH(16), .WAYS(8), .MODE(ARB_RR)) u_rr (
        .clk(clk), .reset(reset), .bus(if_rr.slave));
    mux_arb_way #(.WIDTH(16), .WAYS(8), .MODE(ARB_FIXED)) u_fx (
        .clk(clk), .reset(reset), .bus(if_fx.slave));
    mux_arb_way #(.WIDTH(8), .WAYS(3), .MODE(ARB_RR)) u_sm (
        .clk(clk), .reset(reset), .bus(if_sm.slave));

    // Stimulus, indexed by build: 0 = rr, 1 = fixed, 2 = small
    logic [15:0] s_data [3][8];
    logic [7:0]  s_valid [3];
    logic        s_oready [3];

    logic [127:0] p_rr;
    logic [127:0] p_fx;
    logic [23:0]  p_sm;

    always_comb begin
        p_rr = '0;
        p_fx = '0;
        p_sm = '0;
        for (int i = 0; i < 8; i++) begin
            p_rr[i*16 +: 16] = s_data[0][i];
            p_fx[i*16 +: 16] = s_data[1][i];
        end
        for (int i = 0; i < 3; i++) begin
            p_sm[i*8 +: 8] = s_data[2][i][7:0];
        end
    end

    assign if_rr.in_data   = p_rr;
    assign if_fx.in_data   = p_fx;
    assign if_sm.in_data   = p_sm;
    assign if_rr.in_valid  = s_valid[0];
    assign if_fx.in_valid  = s_valid[1];
    assign if_sm.in_valid  = s_valid[2][2:0];
    assign if_rr.out_ready = s_oready[0];
    assign if_fx.out_ready = s_oready[1];
    assign if_sm.out_ready = s_oready[2];

    // Reference model state per build
    int          m_ways [3] = '{8, 8, 3};
    int          m_mode [3] = '{ARB_RR, ARB_FIXED, ARB_RR};
    bit          m_valid [3];
    logic [15:0] m_out [3];
    int          m_sel [3];
    int          m_last [3];
    logic [7:0]  last_rdy [3];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int d, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s build%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_rdy(input int d);
        case (d)
            0:       return if_rr.in_ready;
            1:       return if_fx.in_ready;
            default: return {5'b0, if_sm.in_ready};
        endcase
    endfunction

    function automatic logic obs_valid(input int d);
        case (d)
            0:       return if_rr.out_valid;
            1:       return if_fx.out_valid;
            default: return if_sm.out_valid;
        endcase
    endfunction

    function automatic logic [15:0] obs_data(input int d);
        case (d)
            0:       return if_rr.out_data;
            1:       return if_fx.out_data;
            default: return {8'h00, if_sm.out_data};
        endcase
    endfunction

    function automatic logic [15:0] obs_sel(input int d);
        case (d)
            0:       return {13'b0, if_rr.out_sel};
            1:       return {13'b0, if_fx.out_sel};
            default: return {14'b0, if_sm.out_sel};
        endcase
    endfunction

    // Channel chosen by the policy: first valid channel found scanning from
    // 0 (fixed) or from last+1 modulo the channel count (round-robin).
    function automatic int pick(input int d);
        int start;
        int c;
        start = (m_mode[d] == ARB_RR) ? (m_last[d] + 1) % m_ways[d] : 0;
        for (int k = 0; k < m_ways[d]; k++) begin
            c = (start + k) % m_ways[d];
            if (s_valid[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic set_data(input int d, input int i, input logic [15:0] v);
        s_data[d][i] = (d == 2) ? {8'h00, v[7:0]} : v;
    endtask

    task automatic set_all(input logic [7:0] vmask, input logic oready);
        for (int d = 0; d < 3; d++) begin
            s_valid[d]  = vmask;
            s_oready[d] = oready;
        end
    endtask

    // One clock: check combinational in_ready, advance model, check outputs.
    task automatic step();
        int         g [3];
        logic [7:0] er [3];
        #2;
        for (int d = 0; d < 3; d++) begin
            g[d] = pick(d);
            if (reset || (m_valid[d] && !s_oready[d]) || g[d] < 0) er[d] = 8'h00;
            else                                                er[d] = 8'(1 << g[d]);
            check("in_ready", d, {8'h00, obs_rdy(d)}, {8'h00, er[d]});
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_valid[d] = 1'b0;
                m_out[d]   = 16'h0000;
                m_sel[d]   = 0;
                m_last[d]  = m_ways[d] - 1;
            end else if (er[d] != 8'h00) begin
                m_valid[d] = 1'b1;
                m_out[d]   = s_data[d][g[d]];
                m_sel[d]   = g[d];
                m_last[d]  = g[d];
            end else if (s_oready[d]) begin
                m_valid[d] = 1'b0;
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            check("out_valid", d, {15'b0, obs_valid(d)}, {15'b0, m_valid[d]});
            check("out_data",  d, obs_data(d), m_out[d]);
            check("out_sel",   d, obs_sel(d), 16'(m_sel[d]));
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) last_rdy[d] = er[d];
    endtask

    int cnt_rr [8];
    int cnt_sm [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_valid[d]  = 1'b0;
            m_out[d]    = 16'h0000;
            m_sel[d]    = 0;
            m_last[d]   = m_ways[d] - 1;
            last_rdy[d] = 8'h00;
            for (int i = 0; i < 8; i++) set_data(d, i, 16'h1000 + 16'(i));
        end
        for (int i = 0; i < 8; i++) cnt_rr[i] = 0;
        for (int i = 0; i < 3; i++) cnt_sm[i] = 0;

        // Reset held two cycles with every channel valid
        reset = 1'b1;
        set_all(8'hFF, 1'b1);
        repeat (2) step();
        reset = 1'b0;

        // Rotation with all valid; count services per channel
        for (int n = 0; n < 10; n++) begin
            step();
            if (n < 8) cnt_rr[if_rr.out_sel] = cnt_rr[if_rr.out_sel] + 1;
            if (n < 6) cnt_sm[if_sm.out_sel] = cnt_sm[if_sm.out_sel] + 1;
        end
        for (int i = 0; i < 8; i++) check("rr_fair8", 0, 16'(cnt_rr[i]), 16'd1);
        for (int i = 0; i < 3; i++) check("rr_fair3", 2, 16'(cnt_sm[i]), 16'd2);

        // Wrap and skip: only channels 2 and 6
        set_all(8'h44, 1'b1);
        repeat (6) step();

        // Fixed priority: channels 1 and 5, then channel 1 drops
        set_all(8'h22, 1'b1);
        repeat (4) step();
        set_all(8'h20, 1'b1);
        repeat (3) step();

        // Backpressure: channel 3 carries BEEF, consumer stalls 4 cycles
        for (int d = 0; d < 3; d++) set_data(d, 3, 16'hBEEF);
        set_all(8'h08, 1'b1);
        step();
        set_all(8'h08, 1'b0);
        repeat (4) step();
        set_all(8'h08, 1'b1);
        repeat (2) step();

        // Reset in the middle of a held word
        set_all(8'hFF, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Randomized traffic obeying the producer hold rule
        for (int n = 0; n < 400; n++) begin
            int density;
            density = (n < 130) ? 30 : ((n < 260) ? 90 : 60);
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < m_ways[d]; i++) begin
                    if (!(s_valid[d][i] && !last_rdy[d][i])) begin
                        s_valid[d][i] = ($urandom_range(0, 99) < density);
                        set_data(d, i, 16'($urandom));
                    end
                end
                s_oready[d] = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
